// File: rtl/music_speech_host_fifo_pkg.sv
// music_speech_host_fifo_pkg: address offsets, status bit positions and soft-reset states
package music_speech_host_fifo_pkg;
    localparam logic [15:0] CTRL_OFS  = 16'd0;
    localparam logic [15:0] DATA_OFS  = 16'd1;
    localparam int          EMPTY_BIT = 7;
    localparam int          FULL_BIT  = 6;
    localparam int          OVF_BIT   = 5;
    localparam int          BUSY_W    = 5;
    typedef enum logic {IDLE, PULSE} rst_state_t;
endpackage

// File: rtl/music_speech_host_fifo_sync_byte_fifo.sv
// sync_byte_fifo: host-to-SOC byte FIFO with push/pop/flush; head byte reads as zero when empty
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic do_pop, do_push;
    assign empty   = cnt == '0;
    assign full    = cnt == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    // a pop frees the slot this same cycle, so a full FIFO still accepts the push
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/music_speech_host_fifo.sv
// music_speech_host_fifo: CPU-side byte FIFO to the sound SOC with status register and soft-reset pulse
module music_speech_host_fifo
    import music_speech_host_fifo_pkg::*;
#(
    parameter logic [1:0]  SLOT       = 2'b01,
    parameter logic [15:0] BASE_ADRS  = 16'hFF7D,
    parameter int          FIFO_DEPTH = 16,
    parameter int          NUM_CH     = 2,
    parameter int          RST_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CLK_EN,
    input  logic [1:0]        MPI_SCS,
    input  logic [15:0]       ADDRESS,
    input  logic              RW_N,
    input  logic [7:0]        WRITE_DATA,
    output logic [7:0]        READ_DATA,
    input  logic [NUM_CH-1:0] CH_BUSY,
    input  logic              SOC_POP,
    input  logic              SOC_FLUSH,
    output logic [7:0]        SOC_DATA,
    output logic              SOC_INT_N,
    output logic              SYS_RESET_N
);
    rst_state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic sel, ctrl_wr, data_wr, stat_rd, start, push, ovf_evt, overflow;
    logic empty, full;
    assign sel     = CLK_EN && MPI_SCS == SLOT;
    assign ctrl_wr = sel && !RW_N && ADDRESS == BASE_ADRS + CTRL_OFS;
    assign data_wr = sel && !RW_N && ADDRESS == BASE_ADRS + DATA_OFS;
    assign stat_rd = sel && RW_N && ADDRESS == BASE_ADRS + CTRL_OFS;
    assign start   = ctrl_wr && WRITE_DATA[0];
    assign push    = data_wr && state == IDLE;
    // a byte lost to a flush is not an overflow
    assign ovf_evt = push && full && !SOC_POP && !SOC_FLUSH;
    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (CLK),
        .reset_n(RESET_N),
        .push   (push),
        .pop    (SOC_POP),
        .flush  (SOC_FLUSH || start),
        .wr_data(WRITE_DATA),
        .rd_data(SOC_DATA),
        .empty  (empty),
        .full   (full)
    );
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            overflow <= start ? 1'b0 : ovf_evt ? 1'b1 : stat_rd ? 1'b0 : overflow;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if (start) begin
                state_n = PULSE;
                cnt_n   = 16'(RST_CYCLES - 1);
            end
        end else if (ctrl_wr) begin
            state_n = WRITE_DATA[0] ? PULSE : IDLE;
            cnt_n   = WRITE_DATA[0] ? 16'(RST_CYCLES - 1) : 16'd0;
        end else if (cnt == 16'd0) begin
            state_n = IDLE;
        end else begin
            cnt_n = cnt - 16'd1;
        end
    end
    assign READ_DATA   = {empty, full, overflow, BUSY_W'(CH_BUSY)};
    assign SOC_INT_N   = empty;
    assign SYS_RESET_N = RESET_N && state == IDLE;
endmodule

// File: tb/tb_music_speech_host_fifo.sv
// tb_music_speech_host_fifo: directed checks of FIFO, status register and soft-reset pulse
module tb_music_speech_host_fifo;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CLK_EN = 1'b0;
    logic [1:0]  MPI_SCS = 2'b01;
    logic [15:0] ADDRESS = 16'h0000;
    logic        RW_N = 1'b1;
    logic [7:0]  WRITE_DATA = 8'h00;
    logic [7:0]  READ_DATA;
    logic [1:0]  CH_BUSY = 2'b00;
    logic        SOC_POP = 1'b0;
    logic        SOC_FLUSH = 1'b0;
    logic [7:0]  SOC_DATA;
    logic        SOC_INT_N;
    logic        SYS_RESET_N;
    int checks = 0;
    int errors = 0;
    int n;
    logic [7:0] d;

    music_speech_host_fifo dut (
        .CLK(CLK), .RESET_N(RESET_N), .CLK_EN(CLK_EN), .MPI_SCS(MPI_SCS),
        .ADDRESS(ADDRESS), .RW_N(RW_N), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
        .CH_BUSY(CH_BUSY), .SOC_POP(SOC_POP), .SOC_FLUSH(SOC_FLUSH), .SOC_DATA(SOC_DATA),
        .SOC_INT_N(SOC_INT_N), .SYS_RESET_N(SYS_RESET_N)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [7:0] v, input logic [1:0] slot = 2'b01);
        @(negedge CLK);
        CLK_EN = 1'b1; MPI_SCS = slot; RW_N = 1'b0; ADDRESS = a; WRITE_DATA = v;
        @(negedge CLK);
        CLK_EN = 1'b0; MPI_SCS = 2'b01; RW_N = 1'b1;
    endtask

    task automatic host_rd(output logic [7:0] v, input logic [1:0] slot = 2'b01);
        @(negedge CLK);
        CLK_EN = 1'b1; MPI_SCS = slot; RW_N = 1'b1; ADDRESS = 16'hFF7D;
        #1 v = READ_DATA;
        @(negedge CLK);
        CLK_EN = 1'b0; MPI_SCS = 2'b01;
    endtask

    task automatic pop();
        @(negedge CLK);
        SOC_POP = 1'b1;
        @(negedge CLK);
        SOC_POP = 1'b0;
    endtask

    task automatic measure_pulse(output int len);
        len = 0;
        while (!SYS_RESET_N && len < 200) begin
            len++;
            @(negedge CLK);
        end
    endtask

    initial begin
        #2;
        chk("rst_int_n", 8'(SOC_INT_N), 8'h01);
        chk("rst_sys_reset_n", 8'(SYS_RESET_N), 8'h00);
        chk("rst_soc_data", SOC_DATA, 8'h00);
        chk("rst_status", READ_DATA, 8'h80);
        @(negedge CLK) RESET_N = 1'b1;
        @(negedge CLK);
        chk("idle_sys_reset_n", 8'(SYS_RESET_N), 8'h01);
        CH_BUSY = 2'b10;
        #1 chk("busy_status", READ_DATA, 8'h82);
        host_wr(16'hFF7E, 8'h99, 2'b10);
        chk("wrong_slot_no_push", READ_DATA, 8'h82);
        CH_BUSY = 2'b00;
        host_wr(16'hFF7E, 8'h11);
        host_wr(16'hFF7E, 8'h22);
        host_wr(16'hFF7E, 8'h33);
        chk("push3_int_n", 8'(SOC_INT_N), 8'h00);
        chk("push3_head", SOC_DATA, 8'h11);
        chk("push3_status", READ_DATA, 8'h00);
        pop();
        chk("pop1_head", SOC_DATA, 8'h22);
        pop();
        chk("pop2_head", SOC_DATA, 8'h33);
        pop();
        chk("pop3_int_n", 8'(SOC_INT_N), 8'h01);
        chk("pop3_status", READ_DATA, 8'h80);
        pop();
        chk("pop_empty_status", READ_DATA, 8'h80);
        CH_BUSY = 2'b01;
        for (int i = 0; i < 17; i++) host_wr(16'hFF7E, 8'h40 + 8'(i));
        chk("overflow_status", READ_DATA, 8'h61);
        chk("overflow_head", SOC_DATA, 8'h40);
        host_rd(d, 2'b11);
        chk("wrong_slot_read_val", d, 8'h61);
        chk("wrong_slot_no_clear", READ_DATA, 8'h61);
        host_rd(d);
        chk("status_read_val", d, 8'h61);
        chk("status_read_clear", READ_DATA, 8'h41);
        @(negedge CLK);
        CLK_EN = 1'b1; RW_N = 1'b0; ADDRESS = 16'hFF7E; WRITE_DATA = 8'hAA; SOC_POP = 1'b1;
        @(negedge CLK);
        CLK_EN = 1'b0; RW_N = 1'b1; SOC_POP = 1'b0;
        chk("full_pushpop_status", READ_DATA, 8'h41);
        chk("full_pushpop_head", SOC_DATA, 8'h41);
        repeat (15) pop();
        chk("aa_last_head", SOC_DATA, 8'hAA);
        chk("aa_last_status", READ_DATA, 8'h01);
        pop();
        chk("drained_status", READ_DATA, 8'h81);
        host_wr(16'hFF7E, 8'h01);
        host_wr(16'hFF7E, 8'h02);
        chk("pre_flush_status", READ_DATA, 8'h01);
        @(negedge CLK);
        CLK_EN = 1'b1; RW_N = 1'b0; ADDRESS = 16'hFF7E; WRITE_DATA = 8'h03; SOC_POP = 1'b1; SOC_FLUSH = 1'b1;
        @(negedge CLK);
        CLK_EN = 1'b0; RW_N = 1'b1; SOC_POP = 1'b0; SOC_FLUSH = 1'b0;
        chk("flush_status", READ_DATA, 8'h81);
        chk("flush_int_n", 8'(SOC_INT_N), 8'h01);
        for (int i = 0; i < 17; i++) host_wr(16'hFF7E, 8'(i));
        chk("pre_pulse_status", READ_DATA, 8'h61);
        host_wr(16'hFF7D, 8'h01);
        chk("pulse_start_status", READ_DATA, 8'h81);
        measure_pulse(n);
        chk("pulse_len", 8'(n), 8'd64);
        host_wr(16'hFF7D, 8'h01);
        repeat (60) @(negedge CLK);
        host_wr(16'hFF7D, 8'h01);
        measure_pulse(n);
        chk("reload_len", 8'(n), 8'd64);
        host_wr(16'hFF7D, 8'h01);
        host_wr(16'hFF7E, 8'h55);
        chk("pulse_push_dropped", READ_DATA, 8'h81);
        repeat (5) @(negedge CLK);
        chk("pre_abort_low", 8'(SYS_RESET_N), 8'h00);
        host_wr(16'hFF7D, 8'h00);
        chk("abort_high", 8'(SYS_RESET_N), 8'h01);
        repeat (3) @(negedge CLK);
        chk("abort_stays_high", 8'(SYS_RESET_N), 8'h01);
        for (int i = 0; i < 17; i++) host_wr(16'hFF7E, 8'hC0 + 8'(i));
        chk("pre_reset_status", READ_DATA, 8'h61);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_int_n", 8'(SOC_INT_N), 8'h01);
        chk("async_rst_soc_data", SOC_DATA, 8'h00);
        chk("async_rst_status", READ_DATA, 8'h81);
        chk("async_rst_sys_n", 8'(SYS_RESET_N), 8'h00);
        @(negedge CLK) RESET_N = 1'b1;
        #1 chk("release_sys_n", 8'(SYS_RESET_N), 8'h01);
        for (int i = 0; i < 5; i++) host_wr(16'hFF7E, 8'h10 + 8'(i));
        chk("queued5_int_n", 8'(SOC_INT_N), 8'h00);
        host_wr(16'hFF7D, 8'h01);
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("midpulse_rst_sys_n", 8'(SYS_RESET_N), 8'h00);
        chk("midpulse_rst_int_n", 8'(SOC_INT_N), 8'h01);
        chk("midpulse_rst_soc_data", SOC_DATA, 8'h00);
        @(negedge CLK) RESET_N = 1'b1;
        #1 chk("midpulse_release_sys_n", 8'(SYS_RESET_N), 8'h01);
        chk("midpulse_release_status", READ_DATA, 8'h81);
        repeat (3) @(negedge CLK);
        chk("after_reset_idle", 8'(SYS_RESET_N), 8'h01);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
